ppu_cpu_reg_port: RTL
=====================

Name: ppu_cpu_reg_port

Overview:
CPU-facing PPU register file. Decodes CPU writes and reads to $2000/$2001/$2002/$2005/$2006/$2007. Produces the scroll pointer and control registers consumed by the pixel-to-nametable address path. Runs the VRAM access handshake for $2007 data port reads and writes.

Parameters:
VRAM_AW, 14, VRAM address width (PPU space $0000-$3FFF)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cpu_reg_sel  input  3  register index 0-7 ($2000-$2007)
cpu_wr_en  input  1  single-cycle write strobe
cpu_rd_en  input  1  single-cycle read strobe
cpu_data_in  input  8  write data
cpu_data_out  output  8  read data, registered
vblank_set  input  1  pulse from timing: set vblank flag
vblank_clr  input  1  pulse from timing (pre-render): clear vblank flag
sprite0_hit  input  1  status bit 6 source
sprite_ovf  input  1  status bit 5 source
cpu_scroll_addr  output  16  {scroll_y[7:0], scroll_x[7:0]}
ppu_ctrl1  output  8  $2000 contents
ppu_ctrl2  output  8  $2001 contents
nmi_n  output  1  active-low NMI, ~(vblank_flag & ppu_ctrl1[7])
vram_req  output  1  VRAM access request, held until ack
vram_we  output  1  1 = write, valid with vram_req
vram_addr  output  VRAM_AW  access address, valid with vram_req
vram_wdata  output  8  write data, valid with vram_req
vram_ack  input  1  arbiter completes access this cycle
vram_rdata  input  8  read data, valid with vram_ack when vram_we=0
busy  output  1  VRAM access in flight

Behaviour:
- Reset (async, rst_n=0): all outputs and registers 0, except nmi_n=1. Write toggle w=0, state IDLE, read buffer 0. Reset mid-transaction aborts: vram_req drops immediately, no address increment.
- Strobes sampled on the rising edge. wr_en and rd_en both high: the write is performed and the read is ignored. Writes to read-only index 2 are ignored. Reads of write-only indices return 0.
- $2000 write: ppu_ctrl1 <= data. nmi_n updates the next cycle; combinational from registers.
- $2001 write: ppu_ctrl2 <= data.
- $2002 read: cpu_data_out <= {vblank_flag, sprite0_hit, sprite_ovf, 5'b0}. Same edge: vblank_flag <= 0 and w <= 0.
- vblank flag precedence: vblank_set in the same cycle as a $2002 read → read returns bit7=0, flag ends set. vblank_set and vblank_clr together → clr wins.
- $2005 write: w=0 → scroll_x <= data, w <= 1. w=1 → scroll_y <= data, w <= 0. cpu_scroll_addr updates the cycle after the write; there is no frame latch.
- $2006 write: w=0 → addr_hi <= data[5:0], w <= 0→1. w=1 → vram_ptr <= {addr_hi, data}, w <= 0. The toggle w is shared with $2005. $2006 never alters scroll.
- $2007 write in IDLE: state WR. From the next cycle vram_req=1, vram_we=1, vram_addr=vram_ptr, vram_wdata=data.
- $2007 read in IDLE: cpu_data_out <= read_buf on the edge (buffered read; all address ranges, palette included). State RD: vram_req=1, vram_we=0.
- On vram_ack in WR or RD:
  - RD only: read_buf <= vram_rdata.
  - vram_ptr <= vram_ptr + (ppu_ctrl1[2] ? 32 : 1), modulo 2^VRAM_AW ($3FFF+1 → $0000, $3FF0+32 → $0010).
  - vram_req drops the same edge; state → IDLE.
- busy = (state != IDLE). A $2007 access while busy is dropped: no request, no increment. A read still returns the current read_buf.
- $2006 write while busy: vram_ptr updates at once. The in-flight vram_addr is a captured copy and does not change. The ack increment applies to the new vram_ptr.
- vram_ack while IDLE: ignored.
- cpu_data_out holds its last value until the next read.

Test Plan:
- $2005 writes 0x7D then 0x3A → cpu_scroll_addr=0x3A7D. Then $2002 read, then $2005 write 0x11 → cpu_scroll_addr=0x3A11 (toggle reset).
- ppu_ctrl1=0x04, $2006 writes 0x23,0xC0, then $2007 write 0x55 → vram_req/we high next cycle, addr 0x23C0, wdata 0x55. Ack after 3 cycles → next write targets 0x23E0.
- $2006 writes 0x20,0x00, vram_rdata=0xAB. First $2007 read returns 0x00, ack loads 0xAB. Second read returns 0xAB; pointer reaches 0x2002.
- ppu_ctrl1=0x00, pointer 0x3FFF, $2007 write acked → pointer 0x0000. With ctrl1[2]=1 from 0x3FF0 → 0x0010.
- Second $2007 write while busy=1 → no second request; exactly one increment after ack.
- ctrl1=0x80, vblank_set pulse → nmi_n=0. $2002 read returns 0x80 and nmi_n=1 next cycle. rst_n low during pending request → vram_req=0 asynchronously, all registers 0.

Source files
------------

// File: rtl/ppu_cpu_reg_port.sv
// CPU-facing PPU register file: $2000/$2001/$2002/$2005/$2006/$2007 decode,
// scroll/control outputs and the $2007 VRAM access handshake.
module ppu_cpu_reg_port #(
  parameter int unsigned VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         cpu_reg_sel,
  input  logic               cpu_wr_en,
  input  logic               cpu_rd_en,
  input  logic [7:0]         cpu_data_in,
  output logic [7:0]         cpu_data_out,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               sprite0_hit,
  input  logic               sprite_ovf,
  output logic [15:0]        cpu_scroll_addr,
  output logic [7:0]         ppu_ctrl1,
  output logic [7:0]         ppu_ctrl2,
  output logic               nmi_n,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e             state_q;
  logic [7:0]         ctrl1_q, ctrl2_q, scroll_x_q, scroll_y_q, read_buf_q, data_out_q;
  logic [7:0]         wdata_q;
  logic [5:0]         addr_hi_q;
  logic [VRAM_AW-1:0] vram_ptr_q, vram_ptr_d, addr_q;
  logic               w_q, vblank_q, vblank_d;
  logic               wr_act, rd_act, acked;
  logic [VRAM_AW-1:0] ptr_inc;

  // A simultaneous write wins over the read.
  assign wr_act  = cpu_wr_en;
  assign rd_act  = cpu_rd_en & ~cpu_wr_en;
  assign acked   = vram_ack & (state_q != StIdle);
  assign ptr_inc = ctrl1_q[2] ? VRAM_AW'(32) : VRAM_AW'(1);

  always_comb begin
    vblank_d = vblank_q;
    if (rd_act && cpu_reg_sel == 3'd2) vblank_d = 1'b0;
    if (vblank_set) vblank_d = 1'b1;
    if (vblank_clr) vblank_d = 1'b0;
  end

  // A $2006 low-byte write landing during an ack is incremented on top of the new value.
  always_comb begin
    vram_ptr_d = vram_ptr_q;
    if (wr_act && cpu_reg_sel == 3'd6 && w_q) vram_ptr_d = VRAM_AW'({addr_hi_q, cpu_data_in});
    if (acked) vram_ptr_d = vram_ptr_d + ptr_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      read_buf_q <= '0;
      data_out_q <= '0;
      wdata_q    <= '0;
      addr_hi_q  <= '0;
      vram_ptr_q <= '0;
      addr_q     <= '0;
      w_q        <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      vblank_q   <= vblank_d;
      vram_ptr_q <= vram_ptr_d;

      if (wr_act) begin
        unique case (cpu_reg_sel)
          3'd0: ctrl1_q <= cpu_data_in;
          3'd1: ctrl2_q <= cpu_data_in;
          3'd5: begin
            if (w_q) scroll_y_q <= cpu_data_in;
            else     scroll_x_q <= cpu_data_in;
            w_q <= ~w_q;
          end
          3'd6: begin
            if (!w_q) addr_hi_q <= cpu_data_in[5:0];
            w_q <= ~w_q;
          end
          3'd7: begin
            if (state_q == StIdle) begin
              state_q <= StWr;
              addr_q  <= vram_ptr_q;
              wdata_q <= cpu_data_in;
            end
          end
          default: ;
        endcase
      end else if (rd_act) begin
        unique case (cpu_reg_sel)
          3'd2: begin
            data_out_q <= {vblank_q & ~vblank_set, sprite0_hit, sprite_ovf, 5'b0};
            w_q        <= 1'b0;
          end
          3'd7: begin
            data_out_q <= read_buf_q;
            if (state_q == StIdle) begin
              state_q <= StRd;
              addr_q  <= vram_ptr_q;
            end
          end
          default: data_out_q <= '0;
        endcase
      end

      if (acked) begin
        if (state_q == StRd) read_buf_q <= vram_rdata;
        state_q <= StIdle;
      end
    end
  end

  assign cpu_data_out    = data_out_q;
  assign cpu_scroll_addr = {scroll_y_q, scroll_x_q};
  assign ppu_ctrl1       = ctrl1_q;
  assign ppu_ctrl2       = ctrl2_q;
  assign nmi_n           = ~(vblank_q & ctrl1_q[7]);
  assign vram_req        = (state_q != StIdle);
  assign vram_we         = (state_q == StWr);
  assign vram_addr       = addr_q;
  assign vram_wdata      = wdata_q;
  assign busy            = (state_q != StIdle);

endmodule
